// File: rtl/draw_num_pkg.sv
// draw_num_pkg: shared types and constant functions for the multi-field number renderer
package draw_num_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} conv_state_t;
  function automatic logic [31:0] max_bcd(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return 32'(p - 64'd1);
  endfunction
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int fid_bits(input int n);
    return n < 2 ? 1 : clog2(n);
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: serial double-dabble converter, one bit per cycle, saturating to all nines
module bin2bcd_seq import draw_num_pkg::*; #(
  parameter int BINARY_BITS = 26,
  parameter int BCD_DIGITS = 8
) (
  input  logic                    vga_clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [BINARY_BITS-1:0]  bin,
  output logic [4*BCD_DIGITS-1:0] bcd,
  output logic                    done
);
  localparam int CW = $clog2(BINARY_BITS + 1);
  logic [BINARY_BITS-1:0] sr;
  logic [4*BCD_DIGITS-1:0] acc, adj;
  logic [CW-1:0] cnt;
  logic run, sat;
  always_comb begin
    adj = acc;
    for (int i = 0; i < BCD_DIGITS; i++)
      adj[4*i +: 4] = acc[4*i +: 4] >= 4'd5 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
  end
  // values wider than the digit count can hold would wrap, so clamp them up front
  always_ff @(posedge vga_clk)
    if (rst || abort) begin
      run <= 1'b0;
      cnt <= '0;
      sr  <= '0;
      acc <= '0;
      sat <= 1'b0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= CW'(BINARY_BITS);
      sr  <= bin;
      acc <= '0;
      sat <= (BCD_DIGITS < 10) && (64'(bin) > 64'(max_bcd(BCD_DIGITS)));
    end else if (run) begin
      {acc, sr} <= {adj, sr} << 1;
      cnt <= cnt - 1'b1;
      run <= cnt != CW'(1);
    end
  assign done = run && cnt == CW'(1);
  assign bcd = sat ? {BCD_DIGITS{4'h9}} : acc;
endmodule

// File: rtl/draw_number_fields.sv
// draw_number_fields: renders NUM_FIELDS decimal fields via one shared BCD converter
// Optional DRAW_NUM_LZB_EN blanks leading zeros (rightmost digit always drawn).
module draw_number_fields import draw_num_pkg::*; #(
  parameter int NUM_FIELDS = 3,
  parameter int BINARY_BITS = 26,
  parameter int BCD_DIGITS = 8,
  parameter int DIGIT_WIDTH = 16,
  parameter int DIGIT_HEIGHT = 20,
  parameter int GLYPH_STRIDE = 320,
  parameter int ADDR_BITS = 12
) (
  input  logic                             vga_clk,
  input  logic                             rst,
  input  logic [10:0]                      x,
  input  logic [9:0]                       y,
  input  logic [NUM_FIELDS*BINARY_BITS-1:0] bin_in,
  input  logic [NUM_FIELDS*11-1:0]         field_x,
  input  logic [NUM_FIELDS*10-1:0]         field_y,
  output logic [ADDR_BITS-1:0]             addr,
  output logic                             dav,
  output logic [fid_bits(NUM_FIELDS)-1:0]  field_id,
  output logic                             conv_busy
);
  localparam int FW = fid_bits(NUM_FIELDS);
  localparam int SPAN = BCD_DIGITS * DIGIT_WIDTH;
  localparam int LW = $clog2(DIGIT_WIDTH);
  if (DIGIT_WIDTH < 1 || (DIGIT_WIDTH & (DIGIT_WIDTH - 1)) != 0) begin : g_dw_chk
    $error("DIGIT_WIDTH must be a power of two");
  end
  conv_state_t state, state_nx;
  logic [FW-1:0] fidx;
  logic [BINARY_BITS-1:0] cap [NUM_FIELDS];
  logic [4*BCD_DIGITS-1:0] pend [NUM_FIELDS];
  logic [4*BCD_DIGITS-1:0] disp [NUM_FIELDS];
  logic [4*BCD_DIGITS-1:0] bcd;
  logic frame_start, done, last, start;
  assign frame_start = x == 11'd0 && y == 10'd0;
  assign last = fidx == FW'(NUM_FIELDS - 1);
  always_ff @(posedge vga_clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // a new frame always wins: in-flight work is dropped and field 0 restarts
  always_comb
    state_nx = frame_start ? LOAD :
               state == LOAD ? SHIFT :
               state == SHIFT ? (done ? STORE : SHIFT) :
               state == STORE ? (last ? IDLE : LOAD) : IDLE;
  always_comb begin
    conv_busy = state != IDLE;
    start = state == LOAD;
  end
  always_ff @(posedge vga_clk)
    if (rst) begin
      fidx <= '0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
        cap[i] <= '0;
        pend[i] <= '0;
        disp[i] <= '0;
      end
    end else if (frame_start) begin
      fidx <= '0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
        cap[i] <= bin_in[i*BINARY_BITS +: BINARY_BITS];
        disp[i] <= pend[i];
      end
    end else if (state == STORE) begin
      pend[fidx] <= bcd;
      if (!last) fidx <= fidx + 1'b1;
    end
  bin2bcd_seq #(.BINARY_BITS(BINARY_BITS), .BCD_DIGITS(BCD_DIGITS)) u_conv (
    .vga_clk(vga_clk),
    .rst(rst),
    .start(start),
    .abort(frame_start),
    .bin(cap[fidx]),
    .bcd(bcd),
    .done(done)
  );
  logic hit, hdraw;
  logic [FW-1:0] hf;
  logic [ADDR_BITS-1:0] haddr;
  int dx, dy, d, sh;
  // scan from the highest index down so the lowest overlapping field wins
  always_comb begin
    hit = 1'b0;
    hdraw = 1'b0;
    hf = '0;
    haddr = '0;
    dx = 0;
    dy = 0;
    d = 0;
    sh = 0;
    for (int f = NUM_FIELDS - 1; f >= 0; f--) begin
      dx = int'(x) - int'(field_x[f*11 +: 11]);
      dy = int'(y) - int'(field_y[f*10 +: 10]);
      d = dx >>> LW;
      sh = 4 * (BCD_DIGITS - 1 - d);
      if (dx >= 0 && dx < SPAN && dy >= 0 && dy < DIGIT_HEIGHT) begin
        hit = 1'b1;
        hf = FW'(f);
        haddr = ADDR_BITS'(int'(4'(disp[f] >> sh)) * GLYPH_STRIDE + dy * DIGIT_WIDTH + (dx & (DIGIT_WIDTH - 1)));
`ifdef DRAW_NUM_LZB_EN
        hdraw = d == BCD_DIGITS - 1 || |(disp[f] >> sh);
`else
        hdraw = 1'b1;
`endif
      end
    end
  end
  always_ff @(posedge vga_clk)
    if (rst) begin
      addr <= '0;
      dav <= 1'b0;
      field_id <= '0;
    end else begin
      dav <= hit && hdraw;
      field_id <= hit ? hf : '0;
      if (hit) addr <= haddr;
    end
endmodule
